serial_sub: RTL and testbench

Bit-serial unsigned subtractor that computes a − b for WIDTH-bit operands, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's ripple-carry adder datapath. It is meant for area-constrained paths where a WIDTH-cycle latency is acceptable. A start/busy/done handshake frames each operation, and the result is held stable between operations.

---
 rtl/serial_sub.sv | 103 ++++++++++
 tb/tb_serial_sub.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop.
// Computes (a - b) mod 2^WIDTH LSB first; result and borrow held between ops.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_sd_nxt;
  logic             w_last;

  assign w_x      = r_sa[0];
  assign w_y      = r_sb[0];
  assign w_d      = w_x ^ w_y ^ r_br;
  assign w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_sd_nxt = {w_d, r_sd[WIDTH-1:1]};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sd    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sd  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_sd  <= w_sd_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + CW'(1);
          // Final bit: publish result including the bit formed this cycle
          if (w_last) begin
            r_diff <= w_sd_nxt;
            r_bout <= w_br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: directed vectors queue expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;
  int dones = 0;

  logic [W:0]   q[$];
  logic [W:0]   e;
  logic [W-1:0] p_diff;
  logic         p_bout;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      dones++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got diff=%0h bout=%0b want none",
                 diff, bout);
      end else begin
        e = q.pop_front();
        chk("sb_diff", 32'(diff), 32'(e[W-1:0]));
        chk("sb_bout", 32'(bout), 32'(e[W]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done", nm);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb,
                        input string nm);
    q.push_back({eb, ed});
    a     = ia;
    b     = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_nodone"}, 32'(done), 32'd0);
      chk({nm, "_hold"}, 32'(diff), 32'(p_diff));
    end
    tick();
    chk({nm, "_busyfall"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd1);
    tick();
    chk({nm, "_donepulse"}, 32'(done), 32'd0);
    chk({nm, "_keep_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_keep_bout"}, 32'(bout), 32'(eb));
    p_diff = ed;
    p_bout = eb;
  endtask

  initial begin
    int d0;
    int gap;
    bit pb;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    p_diff = '0;
    p_bout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);

    run_op(4'd9, 4'd4, 4'd5, 1'b0, "9m4");
    tick();
    run_op(4'd4, 4'd9, 4'hB, 1'b1, "4m9");
    run_op(4'd0, 4'd1, 4'hF, 1'b1, "0m1");
    run_op(4'd15, 4'd15, 4'd0, 1'b0, "15m15");
    run_op(4'd15, 4'd0, 4'hF, 1'b0, "15m0");

    // second start pulse during RUN must be ignored
    d0 = dones;
    q.push_back({1'b0, 4'd5});
    a     = 4'd9;
    b     = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign");
    repeat (4) tick();
    chk("ign_one_done", 32'(dones - d0), 32'd1);
    chk("ign_idle", 32'(busy), 32'd0);
    chk("ign_diff", 32'(diff), 32'd5);
    p_diff = 4'd5;
    p_bout = 1'b0;

    // reset on the third RUN cycle discards the operation
    a     = 4'd4;
    b     = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    p_diff = '0;
    p_bout = 1'b0;
    run_op(4'd7, 4'd3, 4'd4, 1'b0, "7m3");

    // start held high: back-to-back operations
    q.push_back({1'b0, 4'd2});
    q.push_back({1'b1, 4'd14});
    a     = 4'd3;
    b     = 4'd1;
    start = 1'b1;
    tick();
    chk("b2b_busy0", 32'(busy), 32'd1);
    a   = 4'd1;
    b   = 4'd3;
    pb  = busy;
    gap = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (gap == 0 && busy && !pb) begin
        gap   = k;
        start = 1'b0;
      end
      if (gap != 0 && k == gap + 2)
        chk("b2b_hold2", 32'(diff), 32'd2);
      pb = busy;
    end
    chk("b2b_gap", 32'(gap), 32'd6);
    start = 1'b0;
    repeat (3) tick();
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
